// File: rtl/imm_sign_extender.sv
// Immediate widener: sign/zero-extends IN_W -> OUT_W combinationally, plus a registered copy.
// Optional build macro SIGN_EXT_SHL2_EN adds out_shl2 (out_val shifted left by two).
module imm_sign_extender #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IN_W-1:0]  imm_val,
  input  logic             ctrl,
  input  logic             in_valid,
  output logic [OUT_W-1:0] out_val,
  output logic [OUT_W-1:0] out_val_q,
  output logic             out_valid_q
`ifdef SIGN_EXT_SHL2_EN
  ,
  output logic [OUT_W-1:0] out_shl2
`endif
);

  if (IN_W < 1) begin : g_bad_in_w
    $error("imm_sign_extender: IN_W must be >= 1");
  end
  if (IN_W > OUT_W) begin : g_bad_out_w
    $error("imm_sign_extender: IN_W must not exceed OUT_W");
  end

  // ctrl & msb keeps an X on ctrl visible in the upper bits instead of picking a branch
  if (OUT_W > IN_W) begin : g_extend
    logic ext_bit;
    assign ext_bit = ctrl & imm_val[IN_W-1];
    assign out_val = {{(OUT_W-IN_W){ext_bit}}, imm_val};
  end else begin : g_passthru
    assign out_val = imm_val;
  end

`ifdef SIGN_EXT_SHL2_EN
  assign out_shl2 = out_val << 2;
`endif

  logic [OUT_W-1:0] out_val_d;
  logic             out_valid_d;

  always_comb begin
    out_val_d   = out_val_q;
    out_valid_d = 1'b0;
    if (in_valid) begin
      out_val_d   = out_val;
      out_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_val_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_val_q   <= out_val_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_imm_sign_extender.sv
// Self-checking bench for imm_sign_extender (16 -> 32) using an expected-value scoreboard queue.
module tb_imm_sign_extender;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] imm_val;
  logic        ctrl;
  logic        in_valid;
  logic [31:0] out_val;
  logic [31:0] out_val_q;
  logic        out_valid_q;
`ifdef SIGN_EXT_SHL2_EN
  logic [31:0] out_shl2;
`endif

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  logic [31:0] exp_q[$];
  logic [31:0] held_q;

  imm_sign_extender #(.IN_W(16), .OUT_W(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .imm_val     (imm_val),
    .ctrl        (ctrl),
    .in_valid    (in_valid),
    .out_val     (out_val),
    .out_val_q   (out_val_q),
    .out_valid_q (out_valid_q)
`ifdef SIGN_EXT_SHL2_EN
    ,
    .out_shl2    (out_shl2)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got running want finished");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] model_ext(input logic [15:0] imm, input logic c);
    logic [31:0] r;
    r = {16'h0000, imm};
    if (c && imm[15]) r[31:16] = 16'hFFFF;
    return r;
  endfunction

  // Drive one cycle's inputs; accepted transactions go into the scoreboard.
  task automatic drive(input logic r, input logic [15:0] imm, input logic c, input logic v);
    rst      = r;
    imm_val  = imm;
    ctrl     = c;
    in_valid = v;
    if (v && !r) exp_q.push_back(model_ext(imm, c));
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 16'h5555, 1'b0, 1'b1);
      tick();
      n_cmp++;
      if (out_val_q !== 32'h0) begin
        n_err++; $display("FAIL reset_val_q: got %h want %h", out_val_q, 32'h0);
      end
      n_cmp++;
      if (out_valid_q !== 1'b0) begin
        n_err++; $display("FAIL reset_valid_q: got %b want 0", out_valid_q);
      end
    end
    drive(1'b0, 16'h1234, 1'b1, 1'b1);
    #1;
    n_cmp++;
    if (out_val !== 32'h00001234) begin
      n_err++; $display("FAIL first_comb: got %h want %h", out_val, 32'h00001234);
    end
    tick();
    drive(1'b0, 16'h0000, 1'b0, 1'b0);
    n_cmp++;
    if (out_valid_q !== 1'b1) begin
      n_err++; $display("FAIL first_valid_q: got %b want 1", out_valid_q);
    end
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_err++; $display("FAIL first_sb: got empty scoreboard want one entry");
    end else if (out_val_q !== exp_q[0] || out_val_q !== 32'h00001234) begin
      n_err++; $display("FAIL first_val_q: got %h want %h", out_val_q, 32'h00001234);
      void'(exp_q.pop_front());
    end else begin
      void'(exp_q.pop_front());
    end
    held_q = 32'h00001234;
  endtask

  task automatic test_sign_ext;
    logic [15:0] imms [6] = '{16'h8000, 16'h8000, 16'h7FFF, 16'hFFFF, 16'hFFFF, 16'h0001};
    logic        ctls [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [31:0] exps [6] = '{32'hFFFF8000, 32'h00008000, 32'h00007FFF,
                              32'hFFFFFFFF, 32'h0000FFFF, 32'h00000001};
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, imms[i], ctls[i], 1'b0);
      #1;
      n_cmp++;
      if (out_val !== exps[i]) begin
        n_err++; $display("FAIL ext_%0d: imm %h ctrl %b got %h want %h",
                          i, imms[i], ctls[i], out_val, exps[i]);
      end
    end
    tick();
    n_cmp++;
    if (out_val_q !== held_q || out_valid_q !== 1'b0) begin
      n_err++; $display("FAIL ext_hold: got %h/%b want %h/0", out_val_q, out_valid_q, held_q);
    end
  endtask

  task automatic test_hold;
    drive(1'b0, 16'hFFFE, 1'b1, 1'b1);
    tick();
    drive(1'b0, 16'h0001, 1'b1, 1'b0);
    n_cmp++;
    if (out_valid_q !== 1'b1 || exp_q.size() == 0) begin
      n_err++; $display("FAIL hold_valid: got %b want 1", out_valid_q);
    end else begin
      n_cmp++;
      if (out_val_q !== exp_q.pop_front()) begin
        n_err++; $display("FAIL hold_load: got %h want %h", out_val_q, 32'hFFFFFFFE);
      end
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      n_cmp++;
      if (out_val_q !== 32'hFFFFFFFE) begin
        n_err++; $display("FAIL hold_val_%0d: got %h want %h", i, out_val_q, 32'hFFFFFFFE);
      end
      n_cmp++;
      if (out_valid_q !== 1'b0) begin
        n_err++; $display("FAIL hold_drop_%0d: got %b want 0", i, out_valid_q);
      end
    end
    held_q = 32'hFFFFFFFE;
  endtask

  task automatic test_mid_reset;
    drive(1'b0, 16'h9ABC, 1'b1, 1'b1);
    tick();
    n_cmp++;
    if (out_valid_q !== 1'b1 || exp_q.size() == 0 || out_val_q !== exp_q.pop_front()) begin
      n_err++; $display("FAIL midrst_pre: got %h/%b want %h/1", out_val_q, out_valid_q, 32'hFFFF9ABC);
    end
    drive(1'b1, 16'hABCD, 1'b1, 1'b1);
    #1;
    n_cmp++;
    if (out_val !== 32'hFFFFABCD) begin
      n_err++; $display("FAIL midrst_comb: got %h want %h", out_val, 32'hFFFFABCD);
    end
    tick();
    n_cmp++;
    if (out_val_q !== 32'h0 || out_valid_q !== 1'b0) begin
      n_err++; $display("FAIL midrst_clear: got %h/%b want 0/0", out_val_q, out_valid_q);
    end
    drive(1'b0, 16'h0000, 1'b0, 1'b0);
    held_q = 32'h0;
  endtask

  task automatic test_back_to_back;
    logic [15:0] imm;
    logic        c, v;
    for (int i = 0; i < 60; i++) begin
      imm = 16'($urandom);
      if (i % 7 == 0) imm[15] = 1'b1;
      c = 1'($urandom);
      v = (i < 10) ? 1'b1 : 1'($urandom);
      drive(1'b0, imm, c, v);
      #1;
      n_cmp++;
      if (out_val !== model_ext(imm, c)) begin
        n_err++; $display("FAIL b2b_comb_%0d: imm %h ctrl %b got %h want %h",
                          i, imm, c, out_val, model_ext(imm, c));
      end
      tick();
      n_cmp++;
      if (out_valid_q !== v) begin
        n_err++; $display("FAIL b2b_valid_%0d: got %b want %b", i, out_valid_q, v);
      end
      if (v) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL b2b_sb_%0d: got empty scoreboard want entry", i);
        end else begin
          held_q = exp_q.pop_front();
          n_cmp++;
          if (out_val_q !== held_q) begin
            n_err++; $display("FAIL b2b_val_%0d: got %h want %h", i, out_val_q, held_q);
          end
        end
      end else begin
        n_cmp++;
        if (out_val_q !== held_q) begin
          n_err++; $display("FAIL b2b_hold_%0d: got %h want %h", i, out_val_q, held_q);
        end
      end
    end
    drive(1'b0, 16'h0000, 1'b0, 1'b0);
  endtask

`ifdef SIGN_EXT_SHL2_EN
  task automatic test_shl2;
    drive(1'b0, 16'hFFFF, 1'b1, 1'b0);
    #1;
    n_cmp++;
    if (out_shl2 !== 32'hFFFFFFFC) begin
      n_err++; $display("FAIL shl2_neg: got %h want %h", out_shl2, 32'hFFFFFFFC);
    end
    drive(1'b0, 16'h0003, 1'b1, 1'b0);
    #1;
    n_cmp++;
    if (out_shl2 !== 32'h0000000C) begin
      n_err++; $display("FAIL shl2_pos: got %h want %h", out_shl2, 32'h0000000C);
    end
    drive(1'b0, 16'h8001, 1'b0, 1'b0);
    #1;
    n_cmp++;
    if (out_shl2 !== 32'h00020004) begin
      n_err++; $display("FAIL shl2_zext: got %h want %h", out_shl2, 32'h00020004);
    end
  endtask
`endif

  initial begin
    drive(1'b1, 16'h0000, 1'b0, 1'b0);
    #2;
    test_reset();
    test_sign_ext();
    test_hold();
    test_mid_reset();
    test_back_to_back();
`ifdef SIGN_EXT_SHL2_EN
    test_shl2();
`endif
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++; $display("FAIL sb_drain: got %0d leftover entries want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
